// File: rtl/d_cache_ctrl_if.sv
// ============================================================================
// Module : d_cache_ctrl_if
// Brief  : CPU word port and memory line-request signals of the data cache.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface d_cache_ctrl_if;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_address;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_readM;
    logic        mem_writeM;
    logic [15:0] mem_address;

    modport master (
        output cpu_read, cpu_write, cpu_address, cpu_wdata,
        input  cpu_rdata, cpu_ready, mem_readM, mem_writeM, mem_address
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_address, cpu_wdata,
        output cpu_rdata, cpu_ready, mem_readM, mem_writeM, mem_address
    );
endinterface

`default_nettype wire

// File: rtl/d_cache_ctrl.sv
// ============================================================================
// Module : d_cache_ctrl
// Brief  : Direct-mapped write-back/write-allocate data cache, 4x16-bit lines.
//          Optional hit/miss counters enabled by defining DCACHE_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module d_cache_ctrl #(
    parameter int INDEX_BITS  = 2,
    parameter int MEM_LATENCY = 2
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    d_cache_ctrl_if.slave    bus,
    inout  wire [63:0]       mem_data,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 14 - INDEX_BITS;
    localparam int CNT_W = $clog2(MEM_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FILL      = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        addr_q;
    logic [LINES-1:0]   valid_q, dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [63:0]        data_q [LINES];

    logic [INDEX_BITS-1:0] idx, m_idx;
    logic [TAG_W-1:0]      tag_in, m_tag;
    logic [1:0]            word;
    logic                  req, hit, last;
    logic                  miss_evt, wr_hit, wb_done, fill_done;

    assign idx    = bus.cpu_address[2 +: INDEX_BITS];
    assign tag_in = bus.cpu_address[15 -: TAG_W];
    assign word   = bus.cpu_address[1:0];
    // Miss handling runs off the captured address so a dropped request still finishes cleanly.
    assign m_idx  = addr_q[2 +: INDEX_BITS];
    assign m_tag  = addr_q[15 -: TAG_W];
    assign req    = bus.cpu_read | bus.cpu_write;
    assign hit    = valid_q[idx] && (tag_q[idx] == tag_in);
    assign last   = (cnt_q == CNT_W'(MEM_LATENCY - 1));

    assign mem_data = bus.mem_writeM ? data_q[m_idx] : {64{1'bz}};

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bus.cpu_ready   = 1'b0;
        bus.cpu_rdata   = 16'h0000;
        bus.mem_readM   = 1'b0;
        bus.mem_writeM  = 1'b0;
        bus.mem_address = 16'h0000;
        miss_evt        = 1'b0;
        wr_hit          = 1'b0;
        wb_done         = 1'b0;
        fill_done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req && hit) begin
                    bus.cpu_ready = 1'b1;
                    wr_hit        = bus.cpu_write;
                    if (!bus.cpu_write)
                        bus.cpu_rdata = data_q[idx][{word, 4'b0000} +: 16];
                end else if (req) begin
                    miss_evt = 1'b1;
                    cnt_d    = '0;
                    state_d  = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_FILL;
                end
            end
            S_WRITEBACK: begin
                bus.mem_writeM  = 1'b1;
                bus.mem_address = {tag_q[m_idx], m_idx, 2'b00};
                if (last) begin
                    wb_done = 1'b1;
                    cnt_d   = '0;
                    state_d = S_FILL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FILL: begin
                bus.mem_readM   = 1'b1;
                bus.mem_address = {addr_q[15:2], 2'b00};
                if (last) begin
                    fill_done = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= 16'h0000;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (miss_evt)
                addr_q <= bus.cpu_address;
            if (wr_hit)
                dirty_q[idx] <= 1'b1;
            if (wb_done)
                dirty_q[m_idx] <= 1'b0;
            if (fill_done) begin
                valid_q[m_idx] <= 1'b1;
                dirty_q[m_idx] <= 1'b0;
            end
        end
    end

    // Line payload needs no reset: valid_q gates every use of it.
    always_ff @(posedge clk) begin
        if (reset_n && wr_hit)
            data_q[idx][{word, 4'b0000} +: 16] <= bus.cpu_wdata;
        if (reset_n && fill_done) begin
            data_q[m_idx] <= mem_data;
            tag_q[m_idx]  <= m_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count_q, miss_count_q;
    logic        retry_q;

    // The access retried right after a fill was already counted as a miss.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_count_q  <= 16'h0000;
            miss_count_q <= 16'h0000;
            retry_q      <= 1'b0;
        end else begin
            retry_q <= fill_done;
            if (bus.cpu_ready && !retry_q)
                hit_count_q <= hit_count_q + 16'h0001;
            if (miss_evt)
                miss_count_q <= miss_count_q + 16'h0001;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule

`default_nettype wire
